// File: rtl/execute_mc.sv
// execute_mc: execute stage with ALU, compare flags, branch/jump resolution,
// an iterative shift-add multiplier and a halt state, behind a valid/ready output register.
module execute_mc #(
  parameter int WIDTH = 32,
  parameter bit MUL_EN = 1'b1,
  localparam int IRW = 32 + WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  input  logic [IRW-1:0]   ir_i,
  input  logic [WIDTH-1:0] pc_i,
  input  logic [WIDTH-1:0] reg_data1_i,
  input  logic [WIDTH-1:0] reg_data2_i,
  input  logic [1:0]       reg_write_i,
  input  logic             out_ready_i,
  input  logic             flush_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] reg_data1_o,
  output logic [1:0]       reg_write_o,
  output logic [IRW-1:0]   ir_o,
  output logic [WIDTH-1:0] pc_o,
  output logic             pc_set_o,
  output logic [2:0]       ccr_o,
  output logic             halt_o
);
  localparam logic [3:0] T_INH = 4'h0, T_CMP = 4'h3, T_MOV = 4'h4, T_MUL = 4'h7, T_LDI = 4'h9,
                         T_LOAD = 4'ha, T_STORE = 4'hb, T_BRANCH = 4'hc, T_JUMP = 4'hd;
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {S_RUN, S_MUL, S_HALT} state_t;
  state_t state, state_n;
  logic [3:0] ty, op;
  logic sz, borrow, ovf, cond, take, is_mul, is_halt, accept, out_free, mul_last, mul_done;
  logic ltu, lt, eq;
  logic [WIDTH-1:0] ext, sval, uval, off, alu_b, alu, diff, res, target;
  logic [WIDTH-1:0] mul_a, mul_b, acc, mul_prod, pend_pc, pend_r1;
  logic [IRW-1:0] pend_ir;
  logic [1:0] pend_rw;
  logic [CW-1:0] cnt;
  assign ty = ir_i[31:28];
  assign op = ir_i[27:24];
  assign sz = ir_i[0];
  assign ext = ir_i[IRW-1:32];
  assign sval = {{(WIDTH-15){ir_i[15]}}, ir_i[15:1]};
  assign uval = {{(WIDTH-15){1'b0}}, ir_i[15:1]};
  assign off = sval << 2;
  assign alu_b = op[3] ? sval : reg_data2_i;
  assign {borrow, diff} = {1'b0, reg_data1_i} - {1'b0, reg_data2_i};
  assign ovf = (reg_data1_i[WIDTH-1] ^ reg_data2_i[WIDTH-1]) & (reg_data1_i[WIDTH-1] ^ diff[WIDTH-1]);
  assign {ltu, lt, eq} = ccr_o;
  always_comb begin
    alu = '0;
    case (op[2:0])
      3'd0: alu = reg_data1_i & alu_b;
      3'd1: alu = reg_data1_i | alu_b;
      3'd2: alu = reg_data1_i + alu_b;
      3'd3: alu = reg_data1_i - alu_b;
      3'd4: alu = reg_data1_i << alu_b;
      3'd5: alu = $signed(reg_data1_i) >>> alu_b;
      3'd6: alu = reg_data1_i >> alu_b;
      default: alu = reg_data1_i ^ alu_b;
    endcase
  end
  // Branch conditions read the flags registered by earlier compares
  always_comb begin
    cond = 1'b0;
    case (op)
      4'h0: cond = 1'b1;
      4'h1: cond = eq;
      4'h2: cond = ~eq;
      4'h3: cond = ~ltu & ~eq;
      4'h4: cond = ~lt & ~eq;
      4'h5: cond = ~lt;
      4'h6: cond = lt | eq;
      4'h7: cond = lt;
      4'h8: cond = ~ltu;
      4'h9: cond = ltu;
      4'ha: cond = ltu | eq;
      default: cond = 1'b0;
    endcase
  end
  assign take = (ty == T_JUMP) | ((ty == T_BRANCH) & cond);
  assign target = (ty == T_JUMP) ? (sz ? ext : reg_data1_i + off) : pc_i + off;
  assign res = (ty == T_CMP) ? diff :
               (ty == T_LOAD || ty == T_STORE) ? (sz ? ext : reg_data2_i + off) :
               (ty == T_LDI) ? (sz ? ext : uval) :
               (ty == T_MOV) ? reg_data1_i :
               (ty == T_MUL) ? '0 : alu;
  assign is_mul = MUL_EN && (ty == T_MUL);
  assign is_halt = (ty == T_INH) && (op == 4'h4);
  assign out_free = ~out_valid_o | out_ready_i;
  assign accept = in_valid_i & in_ready_o;
  assign mul_last = (state == S_MUL) && (cnt == CW'(WIDTH - 1));
  assign mul_done = mul_last & out_free & ~flush_i;
  assign mul_prod = acc + (mul_b[0] ? mul_a : '0);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state <= S_RUN;
    else state <= state_n;
  always_comb
    state_n = (state == S_MUL && flush_i) ? S_RUN :
              accept ? (is_mul ? S_MUL : is_halt ? S_HALT : S_RUN) :
              mul_done ? S_RUN : state;
  always_comb
    in_ready_o = rst_ni & (state == S_RUN) & ~flush_i & out_free;
  // Multiplier keeps its own operand copy so a stalled output register is never disturbed
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mul_a <= '0;
      mul_b <= '0;
      acc <= '0;
      cnt <= '0;
      pend_pc <= '0;
      pend_r1 <= '0;
      pend_ir <= '0;
      pend_rw <= '0;
    end else if (accept & is_mul) begin
      mul_a <= reg_data1_i;
      mul_b <= reg_data2_i;
      acc <= '0;
      cnt <= '0;
      pend_pc <= pc_i;
      pend_r1 <= reg_data1_i;
      pend_ir <= ir_i;
      pend_rw <= reg_write_i;
    end else if (state == S_MUL && !flush_i && !mul_last) begin
      acc <= mul_prod;
      mul_a <= mul_a << 1;
      mul_b <= mul_b >> 1;
      cnt <= cnt + CW'(1);
    end else if (flush_i | mul_done) begin
      cnt <= '0;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_o <= 1'b0;
      result_o <= '0;
      reg_data1_o <= '0;
      reg_write_o <= '0;
      ir_o <= '0;
      pc_o <= '0;
      pc_set_o <= 1'b0;
      ccr_o <= '0;
      halt_o <= 1'b0;
    end else begin
      if (accept && ty == T_CMP) ccr_o <= {borrow, diff[WIDTH-1] ^ ovf, diff == '0};
      if (accept & is_halt) halt_o <= 1'b1;
      if (flush_i) begin
        out_valid_o <= 1'b0;
        pc_set_o <= 1'b0;
      end else if (accept & ~is_mul) begin
        out_valid_o <= 1'b1;
        result_o <= res;
        reg_data1_o <= reg_data1_i;
        reg_write_o <= reg_write_i;
        ir_o <= ir_i;
        pc_o <= take ? target : pc_i;
        pc_set_o <= take;
      end else if (mul_done) begin
        out_valid_o <= 1'b1;
        result_o <= mul_prod;
        reg_data1_o <= pend_r1;
        reg_write_o <= pend_rw;
        ir_o <= pend_ir;
        pc_o <= pend_pc;
        pc_set_o <= 1'b0;
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
        pc_set_o <= 1'b0;
      end
    end
  end
endmodule

// File: doc/execute_mc.md
EXECUTE_MC -- requirements
Module: execute_mc

Interface
REQ-001 Parameters SHALL be: WIDTH, 32, datapath/address width (>=16); MUL_EN, 1, enables the iterative multiplier; IRW, 32+WIDTH, derived instruction width (not overridable).
REQ-002 Ports SHALL be, in order: clk_i  in  1  clock; rst_ni  in  1  reset.
REQ-003 Reset SHALL be asynchronous and active-low.
REQ-004 Inputs SHALL be: in_valid_i 1 instruction valid; ir_i IRW instruction (ext word in [IRW-1:32]); pc_i WIDTH; reg_data1_i WIDTH; reg_data2_i WIDTH; reg_write_i 2; out_ready_i 1 downstream ready; flush_i 1 kill in-flight work.
REQ-005 Outputs SHALL be: in_ready_o 1; out_valid_o 1; result_o WIDTH; reg_data1_o WIDTH; reg_write_o 2; ir_o IRW; pc_o WIDTH; pc_set_o 1; ccr_o 3 {ltu,lt,eq}; halt_o 1.

Function
REQ-006 Fields: type=ir_i[31:28], op=ir_i[27:24], size=ir_i[0], ext=ir_i[IRW-1:32], sval=ir_i[15:1] sign-extended to WIDTH, uval=ir_i[15:1] zero-extended; type codes per bexkat1Def.
REQ-007 All arithmetic SHALL be modulo 2^WIDTH; offsets for LOAD/STORE/BRANCH/JUMP SHALL be sval<<2 truncated to WIDTH.
REQ-008 FSM states SHALL be S_RUN, S_MUL, S_HALT; reset state S_RUN.
REQ-009 in_ready_o SHALL equal (state==S_RUN) & ~flush_i & (~out_valid_o | out_ready_i).
REQ-010 Accept = in_valid_i & in_ready_o; unaccepted inputs SHALL have no effect.
REQ-011 Single-cycle ops SHALL load the output register on the accepting edge: out_valid_o=1 one cycle after accept (latency 1).
REQ-012 Output register SHALL hold all output fields stable while out_valid_o & ~out_ready_i; out_valid_o clears on out_ready_i with no new result.
REQ-013 Results: ALU op[2:0] on reg_data1_i, reg_data2_i (or sval when op[3]); CMP computes reg_data1_i-reg_data2_i; LOAD/STORE size?ext:reg_data2_i+off; LDI size?ext:uval; MOV reg_data1_i; others ALU output.
REQ-014 CMP accept SHALL update ccr_o on that edge: ltu=borrow, lt=N^V, eq=Z; ccr_o otherwise holds.
REQ-015 BRANCH SHALL evaluate conditions op 0..a (bra,beq,bne,bgtu,bgt,bge,ble,blt,bgeu,bltu,bleu) against registered ccr_o at accept; target pc_i+off; op b..f never taken.
REQ-016 JUMP SHALL always be taken; target size?ext:reg_data1_i+off.
REQ-017 Taken branch/jump: pc_o=target, pc_set_o=1 with out_valid_o; not taken: pc_o=pc_i, pc_set_o=0; pc_set_o SHALL be 0 whenever out_valid_o=0.
REQ-018 Type T_MUL with MUL_EN=1 SHALL enter S_MUL; shift-add counter runs WIDTH cycles; low WIDTH bits of product loaded to output; out_valid_o rises WIDTH+1 cycles after accept.
REQ-019 With MUL_EN=0, T_MUL SHALL complete in 1 cycle with result 0.
REQ-020 In S_MUL in_ready_o SHALL be 0; completion SHALL not occur until output register free; it waits in S_MUL otherwise.
REQ-021 T_INH op 4 SHALL produce an output with halt_o=1 and enter S_HALT; S_HALT is exited only by reset.
REQ-022 flush_i SHALL, on the next edge, clear out_valid_o and pc_set_o and abort S_MUL to S_RUN; ccr_o and halt_o are unaffected.
REQ-023 flush_i and in_valid_i together SHALL accept nothing.

Reset
REQ-024 While rst_ni=0: all outputs 0 except in_ready_o (0), state S_RUN, mul counter 0.
REQ-025 Reset mid-multiply SHALL discard the operation; first cycle after release in_ready_o=1 if flush_i=0.

Verification
REQ-026 ALU add r1=0xFFFFFFFF, r2=2, out_ready_i=1 -> one cycle later out_valid_o=1, result_o=0x00000001.
REQ-027 CMP r1=3,r2=5 then blt pc_i=0x100, sval=4 -> ccr_o=3'b110, pc_o=0x110, pc_set_o=1.
REQ-028 MUL 7x6, WIDTH=32 -> in_ready_o=0 for 32 cycles, result_o=42 at cycle 33.
REQ-029 out_ready_i=0 with out_valid_o=1, new in_valid_i -> in_ready_o=0, outputs held; release -> next accepted.
REQ-030 flush_i during MUL cycle 10 -> out_valid_o stays 0, state S_RUN next cycle, ccr_o unchanged.
REQ-031 halt (T_INH op 4) -> halt_o=1, in_ready_o=0 indefinitely; rst_ni pulse -> halt_o=0, in_ready_o=1.
